// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - table SRAM arbiter for loader, lookup and host, with load bring-up sequencing
module sram_arbiter #(
    parameter int BOOT_DLY   = 1024,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reload,
    output logic        ld_start,
    input  logic        ld_busy,
    input  logic        ld_wen,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    input  logic        lk_req,
    input  logic [15:0] lk_addr,
    output logic        lk_gnt,
    output logic [15:0] lk_rdata,
    output logic        lk_valid,
    input  logic        hs_req,
    input  logic        hs_we,
    input  logic [15:0] hs_addr,
    input  logic [15:0] hs_wdata,
    output logic        hs_gnt,
    output logic [15:0] hs_rdata,
    output logic        hs_valid,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_wen,
    output logic        sram_ren,
    input  logic [15:0] sram_rdata,
    output logic        ready,
    output logic        ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = ($clog2(BOOT_DLY + 1) > 5) ? $clog2(BOOT_DLY + 1) : 5;

    typedef enum logic [1:0] {BOOT, WAIT_BUSY, LOADING, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [31:0]   head;

    // Drain stall hook; tied off so the loader buffer always drains at top priority.
    logic          fifo_hold;
    assign fifo_hold = 1'b0;

    logic              iss_host;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_host;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign head    = fifo_mem[rd_ptr];
    assign pop     = rst && !empty && !fifo_hold;
    assign push_ok = ld_wen && (!full || pop);

    assign lk_gnt  = rst && ready && lk_req && !pop;
    assign hs_gnt  = rst && hs_req && !pop && !lk_gnt;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {ld_addr, ld_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
            if (ld_wen && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= BOOT;
            cnt      <= '0;
            ld_start <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ld_start <= 1'b0;
            case (state)
                BOOT: begin
                    if (cnt == CW'(BOOT_DLY - 1)) begin
                        ld_start <= 1'b1;
                        state    <= WAIT_BUSY;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (ld_busy) begin
                        state <= LOADING;
                        cnt   <= '0;
                    end else if (cnt == CW'(15)) begin
                        state <= BOOT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOADING: begin
                    if (!ld_busy && empty) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (reload) begin
                        state <= BOOT;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_wen   <= 1'b0;
            sram_ren   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            iss_host   <= 1'b0;
        end else begin
            sram_wen <= pop || (hs_gnt && hs_we);
            sram_ren <= lk_gnt || (hs_gnt && !hs_we);
            iss_host <= hs_gnt;
            if (pop) begin
                sram_addr  <= head[31:16];
                sram_wdata <= head[15:0];
            end else if (lk_gnt) begin
                sram_addr <= lk_addr;
            end else if (hs_gnt) begin
                sram_addr <= hs_addr;
                if (hs_we) begin
                    sram_wdata <= hs_wdata;
                end
            end
        end
    end

    // Tracks each issued read from its sram_ren cycle to the cycle its data is on sram_rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_v    <= '0;
            pipe_host <= '0;
        end else begin
            pipe_v[0]    <= sram_ren;
            pipe_host[0] <= iss_host;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_host[i] <= pipe_host[i-1];
            end
        end
    end

    assign lk_valid = pipe_v[RD_LAT-1] && !pipe_host[RD_LAT-1];
    assign hs_valid = pipe_v[RD_LAT-1] && pipe_host[RD_LAT-1];
    assign lk_rdata = lk_valid ? sram_rdata : '0;
    assign hs_rdata = hs_valid ? sram_rdata : '0;

endmodule
